// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// master = operand producer / result consumer, slave = the ALU.
interface alu_seq_if #(
  parameter int unsigned N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Result;
  logic [3:0]   ALUFlags;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, Result, ALUFlags
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, Result, ALUFlags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered valid/ready ALU with NZCV flags. Define ALU_MUL_EN to build the
// iterative shift-add multiplier for op 111; otherwise op 111 returns zero.
module alu_seq #(
  parameter int unsigned N = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int unsigned SW = $clog2(N);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpEor = 3'b100;
  localparam logic [2:0] OpLsl = 3'b101;
  localparam logic [2:0] OpAsr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

  state_e       state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         accept;

  logic [SW-1:0]      shamt;
  logic [N-1:0]       b_eff;
  logic [N:0]         sum;
  logic [N:0]         lsl_ext;
  logic signed [N:0]  asr_ext;
  logic [N-1:0]       alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flags;

`ifdef ALU_MUL_EN
  logic [N-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, prod_step;
  logic [SW-1:0] cnt_q, cnt_d;
`endif

  assign bus.in_ready  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.Result    = result_q;
  assign bus.ALUFlags  = flags_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Single-cycle datapath; the extra top/bottom bit of each wide vector is the carry out.
  always_comb begin
    shamt   = bus.B[SW-1:0];
    b_eff   = (bus.ALUControl == OpSub) ? ~bus.B : bus.B;
    sum     = {1'b0, bus.A} + {1'b0, b_eff} + {{N{1'b0}}, (bus.ALUControl == OpSub)};
    lsl_ext = {1'b0, bus.A} << shamt;
    asr_ext = $signed({bus.A, 1'b0}) >>> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (bus.ALUControl)
      OpAdd, OpSub: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (bus.A[N-1] == b_eff[N-1]) && (sum[N-1] != bus.A[N-1]);
      end
      OpAnd: alu_res = bus.A & bus.B;
      OpOr:  alu_res = bus.A | bus.B;
      OpEor: alu_res = bus.A ^ bus.B;
      OpLsl: begin
        alu_res = lsl_ext[N-1:0];
        alu_c   = lsl_ext[N];
      end
      OpAsr: begin
        alu_res = asr_ext[N:1];
        alu_c   = asr_ext[0];
      end
      OpMul: alu_res = '0;
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[N-1], ~|alu_res, alu_c, alu_v};
  end

`ifdef ALU_MUL_EN
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d  = StDone;
          result_d = alu_res;
          flags_d  = alu_flags;
`ifdef ALU_MUL_EN
          if (bus.ALUControl == OpMul) begin
            state_d  = StBusy;
            result_d = result_q;
            flags_d  = flags_q;
            mcand_d  = bus.A;
            mplier_d = bus.B;
            prod_d   = '0;
            cnt_d    = '0;
          end
`endif
        end else if ((state_q == StDone) && bus.out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef ALU_MUL_EN
      StBusy: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        // Last multiplier bit consumed: publish product; counter wraps back to 0.
        if (cnt_q == SW'(N - 1)) begin
          state_d  = StDone;
          result_d = prod_step;
          flags_d  = {prod_step[N-1], ~|prod_step, 2'b00};
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule
